// File: rtl/extern_return_router_switch_node_multi.sv
`default_nettype none
// ============================================================================
// Module      : extern_return_router_switch_node_multi
// Description : One router stage of the extern return chain serving
//               NUM_LOCAL_PORTS local consumers. Each incoming word is steered
//               by its match counter either into the FIFO of one local port
//               or into a 2-entry registered skid toward the next node. When
//               a word goes downstream, its counter is rebased by
//               NUM_LOCAL_PORTS. Delivery is strictly in order: a stalled
//               destination blocks every later word.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - upstream handshake
//               in_match_counter   - route selector (CW bits)
//               in_data            - payload
//               pass_*             - downstream handshake, rebased selector,
//                                    payload
//               local_valid/ready  - per-port FIFO handshake
//               local_data         - port k at [k*DATA_WIDTH +: DATA_WIDTH]
//               local_count        - port k occupancy at [k*LW +: LW]
// Revision    : 1.0 - initial release
// ============================================================================
module extern_return_router_switch_node_multi #(
   parameter  int NUM_OUTPUT_PORTS = 8,
   parameter  int NUM_LOCAL_PORTS  = 2,
   parameter  int DATA_WIDTH       = 16,
   parameter  int LOCAL_FIFO_DEPTH = 4,
   localparam int CW               = $clog2(NUM_OUTPUT_PORTS) + 1,
   localparam int LW               = $clog2(LOCAL_FIFO_DEPTH) + 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [CW-1:0]                        in_match_counter,
   input  logic [DATA_WIDTH-1:0]                in_data,
   output logic                                 pass_valid,
   input  logic                                 pass_ready,
   output logic [CW-1:0]                        pass_match_counter,
   output logic [DATA_WIDTH-1:0]                pass_data,
   output logic [NUM_LOCAL_PORTS-1:0]           local_valid,
   input  logic [NUM_LOCAL_PORTS-1:0]           local_ready,
   output logic [NUM_LOCAL_PORTS*DATA_WIDTH-1:0] local_data,
   output logic [NUM_LOCAL_PORTS*LW-1:0]        local_count
);

   localparam int             c_ptr_w     = $clog2(LOCAL_FIFO_DEPTH);
   localparam int             c_slot_w    = CW + DATA_WIDTH;
   localparam logic [CW-1:0]  c_num_local = CW'(NUM_LOCAL_PORTS);
   localparam logic [LW-1:0]  c_depth     = LW'(LOCAL_FIFO_DEPTH);

   // Goes high the first cycle after reset is released; keeps in_ready low
   // throughout reset without a combinational path from rst.
   logic r_run;

   logic                       w_is_local;
   logic                       w_sel_full;
   logic                       w_skid_free;
   logic                       w_accept;
   logic                       w_pass_push;
   logic                       w_pass_pop;
   logic [CW-1:0]              w_pass_mc;
   logic [NUM_LOCAL_PORTS-1:0] w_full;
   logic [NUM_LOCAL_PORTS-1:0] w_push;
   logic [NUM_LOCAL_PORTS-1:0] w_pop;

   logic [1:0]                 r_skid_cnt;
   logic [c_slot_w-1:0]        r_slot0;
   logic [c_slot_w-1:0]        r_slot1;
   logic [c_slot_w-1:0]        w_slot_in;

   always_ff @(posedge clk) begin
      if (rst) r_run <= 1'b0;
      else     r_run <= 1'b1;
   end

   // ------------------------------------------------------------------------
   // Route decode and input acceptance
   // ------------------------------------------------------------------------
   assign w_is_local = (in_match_counter < c_num_local);
   assign w_pass_mc  = in_match_counter - c_num_local;

   always_comb begin
      w_sel_full = 1'b0;
      for (int k = 0; k < NUM_LOCAL_PORTS; k++) begin
         if (in_match_counter == CW'(k)) w_sel_full = w_full[k];
      end
   end

   assign w_skid_free = (r_skid_cnt != 2'd2);

   // Depends only on registered state and the selector, never on valid/ready.
   assign in_ready    = r_run & (w_is_local ? ~w_sel_full : w_skid_free);
   assign w_accept    = in_valid & in_ready;
   assign w_pass_push = w_accept & ~w_is_local;
   assign w_pass_pop  = pass_valid & pass_ready;

   // ------------------------------------------------------------------------
   // Local FIFOs, one per consumer
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < NUM_LOCAL_PORTS; k++) begin : g_local
         logic [DATA_WIDTH-1:0] r_mem [LOCAL_FIFO_DEPTH];
         logic [c_ptr_w-1:0]    r_wr_ptr;
         logic [c_ptr_w-1:0]    r_rd_ptr;
         logic [LW-1:0]         r_count;

         assign w_full[k] = (r_count == c_depth);
         assign w_push[k] = w_accept & w_is_local & (in_match_counter == CW'(k));
         assign w_pop[k]  = (r_count != '0) & local_ready[k];

         always_ff @(posedge clk) begin
            if (w_push[k]) r_mem[r_wr_ptr] <= in_data;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_push[k]) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
               if (w_pop[k])  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
               case ({w_push[k], w_pop[k]})
                  2'b10:   r_count <= r_count + LW'(1);
                  2'b01:   r_count <= r_count - LW'(1);
                  default: r_count <= r_count;
               endcase
            end
         end

         assign local_valid[k]                           = (r_count != '0);
         assign local_data[k*DATA_WIDTH +: DATA_WIDTH]   = r_mem[r_rd_ptr];
         assign local_count[k*LW +: LW]                  = r_count;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Pass skid: slot0 is always the head; slot1 holds the second entry.
   // ------------------------------------------------------------------------
   assign w_slot_in = {w_pass_mc, in_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_skid_cnt <= 2'd0;
      end else begin
         case ({w_pass_push, w_pass_pop})
            2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
            2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
            default: r_skid_cnt <= r_skid_cnt;
         endcase
      end
   end

   // Payload slots carry no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      case ({w_pass_push, w_pass_pop})
         2'b10: begin
            if (r_skid_cnt == 2'd0) r_slot0 <= w_slot_in;
            else                    r_slot1 <= w_slot_in;
         end
         2'b01: begin
            r_slot0 <= r_slot1;
         end
         2'b11: begin
            if (r_skid_cnt == 2'd1) begin
               r_slot0 <= w_slot_in;
            end else begin
               r_slot0 <= r_slot1;
               r_slot1 <= w_slot_in;
            end
         end
         default: ;
      endcase
   end

   assign pass_valid                      = (r_skid_cnt != 2'd0);
   assign {pass_match_counter, pass_data} = r_slot0;

endmodule
`default_nettype wire

// File: tb/tb_extern_return_router_switch_node_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_extern_return_router_switch_node_multi
// Description : Directed tests for the multi-port extern return router switch
//               node (default parameters: CW=4, two local ports, depth 4),
//               followed by a scoreboarded random soak with one reset pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extern_return_router_switch_node_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_match_counter;
   logic [15:0] in_data;
   logic        pass_valid;
   logic        pass_ready;
   logic [3:0]  pass_match_counter;
   logic [15:0] pass_data;
   logic [1:0]  local_valid;
   logic [1:0]  local_ready;
   logic [31:0] local_data;
   logic [5:0]  local_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   extern_return_router_switch_node_multi dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_match_counter   (in_match_counter),
      .in_data            (in_data),
      .pass_valid         (pass_valid),
      .pass_ready         (pass_ready),
      .pass_match_counter (pass_match_counter),
      .pass_data          (pass_data),
      .local_valid        (local_valid),
      .local_ready        (local_ready),
      .local_data         (local_data),
      .local_count        (local_count)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [15:0] d);
      in_valid         = 1'b1;
      in_match_counter = c;
      in_data          = d;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1; pass_ready = 1'b0; local_ready = 2'b00;
      drive(4'd0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         step;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         total++; if (pass_valid !== 1'b0) begin bad++; $display("FAIL rst_pass_valid cyc=%0d got=%b exp=0", i, pass_valid); end
         total++; if (local_valid !== 2'b00) begin bad++; $display("FAIL rst_local_valid cyc=%0d got=%b exp=00", i, local_valid); end
         total++; if (local_count !== 6'd0) begin bad++; $display("FAIL rst_local_count cyc=%0d got=%h exp=0", i, local_count); end
      end
      rst = 1'b0; in_valid = 1'b0;
      step;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release in_ready got=%b exp=1", in_ready); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_routing;
      pass_ready = 1'b0; local_ready = 2'b00;
      drive(4'd0, 16'h1234); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rt_c0_ready got=%b exp=1", in_ready); end
      step; in_valid = 1'b0; #1;
      total++; if (local_valid !== 2'b01) begin bad++; $display("FAIL rt_c0_valid got=%b exp=01", local_valid); end
      total++; if (local_data[15:0] !== 16'h1234) begin bad++; $display("FAIL rt_c0_data got=%h exp=1234", local_data[15:0]); end
      total++; if (local_count[2:0] !== 3'd1) begin bad++; $display("FAIL rt_c0_count got=%0d exp=1", local_count[2:0]); end
      local_ready = 2'b01; step; local_ready = 2'b00;

      drive(4'd1, 16'hBEEF); step; in_valid = 1'b0; #1;
      total++; if (local_valid !== 2'b10) begin bad++; $display("FAIL rt_c1_valid got=%b exp=10", local_valid); end
      total++; if (local_data[31:16] !== 16'hBEEF) begin bad++; $display("FAIL rt_c1_data got=%h exp=beef", local_data[31:16]); end
      local_ready = 2'b10; step; local_ready = 2'b00;

      drive(4'd5, 16'h0042); step; in_valid = 1'b0; #1;
      total++; if (pass_valid !== 1'b1) begin bad++; $display("FAIL rt_c5_valid got=%b exp=1", pass_valid); end
      total++; if (pass_match_counter !== 4'd3) begin bad++; $display("FAIL rt_c5_counter got=%0d exp=3", pass_match_counter); end
      total++; if (pass_data !== 16'h0042) begin bad++; $display("FAIL rt_c5_data got=%h exp=0042", pass_data); end
      total++; if (local_valid !== 2'b00) begin bad++; $display("FAIL rt_c5_local got=%b exp=00", local_valid); end
      pass_ready = 1'b1; step; pass_ready = 1'b0; #1;
      total++; if (pass_valid !== 1'b0) begin bad++; $display("FAIL rt_c5_drained got=%b exp=0", pass_valid); end

      drive(4'd2, 16'h0777); step; in_valid = 1'b0; #1;
      total++; if (pass_match_counter !== 4'd0) begin bad++; $display("FAIL rt_c2_counter got=%0d exp=0", pass_match_counter); end
      total++; if (pass_data !== 16'h0777) begin bad++; $display("FAIL rt_c2_data got=%h exp=0777", pass_data); end
      pass_ready = 1'b1; step; pass_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_local_full;
      logic [3:0]  cs [6];
      logic [15:0] ds [6];
      logic [15:0] got_l [$];
      logic [3:0]  got_pm [$];
      logic [15:0] got_pd [$];
      int idx;
      bit acc;
      cs = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
      ds = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'h0077};
      local_ready = 2'b00; pass_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(cs[i], ds[i]); #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_fill_ready i=%0d got=%b exp=1", i, in_ready); end
         step;
      end
      drive(cs[4], ds[4]); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      total++; if (local_count[2:0] !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", local_count[2:0]); end
      for (int i = 0; i < 3; i++) begin
         step;
         total++; if (in_ready !== 1'b0 || pass_valid !== 1'b0) begin bad++; $display("FAIL full_hol i=%0d in_ready=%b pass_valid=%b exp=0,0", i, in_ready, pass_valid); end
      end
      local_ready = 2'b01;
      idx = 4;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx < 6) drive(cs[idx], ds[idx]); else in_valid = 1'b0;
         #1;
         acc = in_valid && in_ready;
         if (local_valid[0] && local_ready[0]) got_l.push_back(local_data[15:0]);
         if (pass_valid && pass_ready) begin got_pm.push_back(pass_match_counter); got_pd.push_back(pass_data); end
         step;
         if (acc) idx++;
      end
      in_valid = 1'b0; local_ready = 2'b00;
      total++;
      if (got_l.size() != 5) begin bad++; $display("FAIL full_drain_count got=%0d exp=5", got_l.size()); end
      else for (int i = 0; i < 5; i++) begin
         total++; if (got_l[i] !== 16'(i)) begin bad++; $display("FAIL full_drain_order i=%0d got=%0d exp=%0d", i, got_l[i], i); end
      end
      total++;
      if (got_pm.size() != 1) begin bad++; $display("FAIL full_pass_count got=%0d exp=1", got_pm.size()); end
      else if (got_pm[0] !== 4'd5 || got_pd[0] !== 16'h0077) begin
         bad++; $display("FAIL full_pass_word got=%0d/%h exp=5/0077", got_pm[0], got_pd[0]);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_simul_push_pop;
      local_ready = 2'b00;
      drive(4'd1, 16'hA001); step;
      drive(4'd1, 16'hA002); step;
      in_valid = 1'b0; #1;
      total++; if (local_count[5:3] !== 3'd2) begin bad++; $display("FAIL pp_pre_count got=%0d exp=2", local_count[5:3]); end
      drive(4'd1, 16'hA003); local_ready = 2'b10; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pp_ready got=%b exp=1", in_ready); end
      total++; if (local_data[31:16] !== 16'hA001) begin bad++; $display("FAIL pp_head got=%h exp=a001", local_data[31:16]); end
      step; in_valid = 1'b0; local_ready = 2'b00; #1;
      total++; if (local_count[5:3] !== 3'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", local_count[5:3]); end
      total++; if (local_data[31:16] !== 16'hA002) begin bad++; $display("FAIL pp_next got=%h exp=a002", local_data[31:16]); end
      local_ready = 2'b10; step; #1;
      total++; if (local_data[31:16] !== 16'hA003 || local_count[5:3] !== 3'd1) begin bad++; $display("FAIL pp_last got=%h/%0d exp=a003/1", local_data[31:16], local_count[5:3]); end
      step; local_ready = 2'b00; #1;
      total++; if (local_valid !== 2'b00) begin bad++; $display("FAIL pp_empty got=%b exp=00", local_valid); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_pass_backpressure;
      logic [15:0] ds [3];
      logic [3:0]  got_pm [$];
      logic [15:0] got_pd [$];
      int idx;
      bit acc;
      ds = '{16'h0A00, 16'h0A01, 16'h0A02};
      pass_ready = 1'b0; local_ready = 2'b00;
      drive(4'd4, ds[0]); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", in_ready); end
      step;
      drive(4'd4, ds[1]); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
      step;
      drive(4'd4, ds[2]); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
      total++; if (pass_valid !== 1'b1 || pass_data !== 16'h0A00 || pass_match_counter !== 4'd2) begin
         bad++; $display("FAIL bp_head got=%b/%h/%0d exp=1/0a00/2", pass_valid, pass_data, pass_match_counter); end
      step;
      total++; if (in_ready !== 1'b0 || pass_data !== 16'h0A00) begin bad++; $display("FAIL bp_hold got=%b/%h exp=0/0a00", in_ready, pass_data); end
      pass_ready = 1'b1;
      idx = 2;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (idx < 3) drive(4'd4, ds[idx]); else in_valid = 1'b0;
         #1;
         acc = in_valid && in_ready;
         if (pass_valid && pass_ready) begin got_pm.push_back(pass_match_counter); got_pd.push_back(pass_data); end
         step;
         if (acc) idx++;
      end
      in_valid = 1'b0; pass_ready = 1'b0;
      total++;
      if (got_pd.size() != 3) begin bad++; $display("FAIL bp_drain_count got=%0d exp=3", got_pd.size()); end
      else for (int i = 0; i < 3; i++) begin
         total++; if (got_pd[i] !== ds[i] || got_pm[i] !== 4'd2) begin bad++; $display("FAIL bp_order i=%0d got=%h/%0d exp=%h/2", i, got_pd[i], got_pm[i], ds[i]); end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back;
      local_ready = 2'b01; pass_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(4'd0, 16'h0100 + 16'(i)); #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
         if (i > 0) begin
            total++;
            if (local_valid[0] !== 1'b1 || local_data[15:0] !== 16'h0100 + 16'(i - 1) || local_count[2:0] !== 3'd1) begin
               bad++; $display("FAIL b2b_out i=%0d got=%b/%h/%0d exp=1/%h/1", i, local_valid[0], local_data[15:0], local_count[2:0], 16'h0100 + 16'(i - 1));
            end
         end
         step;
      end
      in_valid = 1'b0; #1;
      total++; if (local_data[15:0] !== 16'h0105) begin bad++; $display("FAIL b2b_last got=%h exp=0105", local_data[15:0]); end
      step;
      total++; if (local_valid !== 2'b00) begin bad++; $display("FAIL b2b_empty got=%b exp=00", local_valid); end
      local_ready = 2'b00; pass_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_random_soak;
      logic [15:0] q0 [$];
      logic [15:0] q1 [$];
      logic [19:0] qp [$];
      logic [15:0] e16;
      logic [19:0] e20;
      logic [3:0]  cur_c;
      logic [15:0] cur_d;
      int  sent, cyc, recv;
      int  hold [3];
      bit  lvl  [3];
      bit  rst_done, acc;
      sent = 0; cyc = 0; recv = 0; rst_done = 1'b0;
      hold = '{0, 0, 0}; lvl = '{1'b1, 1'b1, 1'b1};
      cur_c = 4'($urandom_range(7, 0)); cur_d = 16'(sent);
      while ((sent < 10000 || q0.size() + q1.size() + qp.size() != 0) && cyc < 60000) begin
         if (!rst_done && sent == 5000) begin
            in_valid = 1'b0; local_ready = 2'b00; pass_ready = 1'b0; rst = 1'b1;
            step; cyc++;
            rst = 1'b0;
            q0.delete(); q1.delete(); qp.delete();
            rst_done = 1'b1;
            total++; if (local_valid !== 2'b00 || pass_valid !== 1'b0) begin bad++; $display("FAIL soak_reset_flush got=%b/%b exp=00/0", local_valid, pass_valid); end
         end
         for (int o = 0; o < 3; o++) begin
            if (hold[o] == 0) begin lvl[o] = 1'($urandom_range(1, 0)); hold[o] = $urandom_range(3, 1); end
            hold[o]--;
            if (sent >= 10000) lvl[o] = 1'b1;
         end
         local_ready = {lvl[1], lvl[0]}; pass_ready = lvl[2];
         if (sent < 10000) drive(cur_c, cur_d); else in_valid = 1'b0;
         #1;
         if (local_valid[0] && local_ready[0]) begin
            total++; recv++;
            e16 = (q0.size() != 0) ? q0.pop_front() : 16'hxxxx;
            if (local_data[15:0] !== e16) begin bad++; $display("FAIL soak_port0 got=%h exp=%h", local_data[15:0], e16); end
         end
         if (local_valid[1] && local_ready[1]) begin
            total++; recv++;
            e16 = (q1.size() != 0) ? q1.pop_front() : 16'hxxxx;
            if (local_data[31:16] !== e16) begin bad++; $display("FAIL soak_port1 got=%h exp=%h", local_data[31:16], e16); end
         end
         if (pass_valid && pass_ready) begin
            total++; recv++;
            e20 = (qp.size() != 0) ? qp.pop_front() : 20'hxxxxx;
            if ({pass_match_counter, pass_data} !== e20) begin bad++; $display("FAIL soak_pass got=%h exp=%h", {pass_match_counter, pass_data}, e20); end
         end
         acc = in_valid && in_ready;
         step; cyc++;
         if (acc) begin
            if (cur_c == 4'd0)      q0.push_back(cur_d);
            else if (cur_c == 4'd1) q1.push_back(cur_d);
            else                    qp.push_back({cur_c - 4'd2, cur_d});
            sent++;
            cur_c = 4'($urandom_range(7, 0)); cur_d = 16'(sent);
         end
      end
      in_valid = 1'b0; local_ready = 2'b00; pass_ready = 1'b0;
      total++; if (cyc >= 60000) begin bad++; $display("FAIL soak_timeout cycles=%0d limit=60000 sent=%0d", cyc, sent); end
      total++; if (sent != 10000) begin bad++; $display("FAIL soak_sent got=%0d exp=10000", sent); end
      total++; if (q0.size() + q1.size() + qp.size() != 0) begin bad++; $display("FAIL soak_leftover got=%0d exp=0", q0.size() + q1.size() + qp.size()); end
      total++; if (local_valid !== 2'b00 || pass_valid !== 1'b0) begin bad++; $display("FAIL soak_extra got=%b/%b exp=00/0", local_valid, pass_valid); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_match_counter = '0; in_data = '0;
      pass_ready = 1'b0; local_ready = 2'b00;
      test_reset;
      test_routing;
      test_local_full;
      test_simul_push_pop;
      test_pass_backpressure;
      test_back_to_back;
      test_random_soak;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
